// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 instruction codes and register IDs shared by decode and regfile
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam int NUM_REGS = 15;

endpackage

// File: rtl/y86_regfile.sv
// rtl/y86_regfile.sv - 15 x 64-bit register file, two read ports, debug read, E/M write ports
module y86_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_RSP = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  input  logic [3:0]  dbg_sel,
  output logic [63:0] val_a,
  output logic [63:0] val_b,
  output logic [63:0] dbg_data,
  input  logic        we,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m
);

  logic [63:0] rf [0:NUM_REGS-1];

  // M is checked first so popq %rsp leaves the popped value in %rsp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        rf[i] <= (4'(i) == RRSP) ? RESET_RSP : 64'h0;
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (dst_m == 4'(i))
          rf[i] <= val_m;
        else if (dst_e == 4'(i))
          rf[i] <= val_e;
      end
    end
  end

  assign val_a    = (src_a   == RNONE) ? 64'h0 : rf[src_a];
  assign val_b    = (src_b   == RNONE) ? 64'h0 : rf[src_b];
  assign dbg_data = (dbg_sel == RNONE) ? 64'h0 : rf[dbg_sel];

endmodule

// File: rtl/decode_writeback.sv
// rtl/decode_writeback.sv - Y86-64 decode (register ID selection) and write-back stage
module decode_writeback
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_RSP = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        wb_en,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic        decode_err,
  input  logic [3:0]  dbg_sel,
  output logic [63:0] dbg_data
);

  logic unused_ifun;
  assign unused_ifun = ^ifun;

  always_comb begin
    srcA       = RNONE;
    srcB       = RNONE;
    dstE       = RNONE;
    dstM       = RNONE;
    decode_err = 1'b0;
    case (icode)
      IRRMOVQ: begin
        srcA = rA;
        dstE = cnd ? rB : RNONE;
      end
      IIRMOVQ: dstE = rB;
      IRMMOVQ: begin
        srcA = rA;
        srcB = rB;
      end
      IMRMOVQ: begin
        srcB = rB;
        dstM = rA;
      end
      IOPQ: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      ICALL: begin
        srcB = RRSP;
        dstE = RRSP;
      end
      IRET: begin
        srcA = RRSP;
        srcB = RRSP;
        dstE = RRSP;
      end
      IPUSHQ: begin
        srcA = rA;
        srcB = RRSP;
        dstE = RRSP;
      end
      IPOPQ: begin
        srcA = RRSP;
        srcB = RRSP;
        dstE = RRSP;
        dstM = rA;
      end
      IHALT, INOP, IJXX: ;
      default: decode_err = 1'b1;
    endcase
  end

  y86_regfile #(
    .RESET_RSP (RESET_RSP)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_a    (srcA),
    .src_b    (srcB),
    .dbg_sel  (dbg_sel),
    .val_a    (valA),
    .val_b    (valB),
    .dbg_data (dbg_data),
    .we       (wb_en),
    .dst_e    (dstE),
    .val_e    (valE),
    .dst_m    (dstM),
    .val_m    (valM)
  );

endmodule

// File: tb/tb_decode_writeback.sv
// tb/tb_decode_writeback.sv - directed self-checking bench for decode_writeback
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  icode, ifun, rA, rB;
  logic        cnd;
  logic [63:0] valE, valM;
  logic        wb_en;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valA, valB;
  logic        decode_err;
  logic [3:0]  dbg_sel;
  logic [63:0] dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decode_writeback #(.RESET_RSP(64'h100)) dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .cnd(cnd), .valE(valE), .valM(valM), .wb_en(wb_en),
    .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .valA(valA), .valB(valB), .decode_err(decode_err),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  task automatic set_in(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic [63:0] e, input logic [63:0] m,
                        input logic en);
    icode = ic; ifun = 4'h0; rA = a; rB = b; cnd = c; valE = e; valM = m; wb_en = en;
  endtask

  task automatic test_reset;
    logic [63:0] exp;
    rst_n = 1'b0;
    set_in(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
    #2;
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i);
      #1;
      exp = (i == 4) ? 64'h100 : 64'h0;
      n_cmp++;
      if (dbg_data !== exp) begin
        n_bad++;
        $display("FAIL reset_r%0d: got %h expected %h", i, dbg_data, exp);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_decode;
    logic [3:0]  ic [8] = '{4'h0, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
    logic [15:0] ex [8] = '{16'hFFFF, 16'h12FF, 16'hF2F1, 16'hFFFF,
                            16'hF44F, 16'h444F, 16'h144F, 16'h4441};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_in(ic[i], 4'h1, 4'h2, 1'b0, 64'h0, 64'h0, 1'b0);
      #2;
      n_cmp++;
      if ({srcA, srcB, dstE, dstM} !== ex[i] || decode_err !== 1'b0) begin
        n_bad++;
        $display("FAIL decode_icode%h: got %h err %b expected %h err 0",
                 ic[i], {srcA, srcB, dstE, dstM}, decode_err, ex[i]);
      end
    end
  endtask

  task automatic test_opq;
    @(negedge clk);
    set_in(4'h3, 4'hF, 4'h3, 1'b0, 64'h5, 64'h0, 1'b1);
    @(negedge clk);
    set_in(4'h6, 4'h0, 4'h3, 1'b0, 64'h0, 64'h0, 1'b0);
    #2;
    n_cmp++;
    if (valB !== 64'h5) begin
      n_bad++; $display("FAIL opq_valB: got %h expected 5", valB);
    end
    n_cmp++;
    if ({srcA, srcB, dstE} !== 12'h033) begin
      n_bad++; $display("FAIL opq_ids: got %h expected 033", {srcA, srcB, dstE});
    end
  endtask

  task automatic test_cmov;
    dbg_sel = 4'h2;
    @(negedge clk);
    set_in(4'h2, 4'h1, 4'h2, 1'b0, 64'h9, 64'h0, 1'b1);
    #2;
    n_cmp++;
    if (dstE !== 4'hF) begin
      n_bad++; $display("FAIL cmov_nc_dstE: got %h expected F", dstE);
    end
    @(negedge clk);
    n_cmp++;
    if (dbg_data !== 64'h0) begin
      n_bad++; $display("FAIL cmov_nc_r2: got %h expected 0", dbg_data);
    end
    cnd = 1'b1;
    #2;
    n_cmp++;
    if (dstE !== 4'h2) begin
      n_bad++; $display("FAIL cmov_c_dstE: got %h expected 2", dstE);
    end
    @(negedge clk);
    wb_en = 1'b0;
    n_cmp++;
    if (dbg_data !== 64'h9) begin
      n_bad++; $display("FAIL cmov_c_r2: got %h expected 9", dbg_data);
    end
  endtask

  task automatic test_popq_rsp;
    dbg_sel = 4'h4;
    @(negedge clk);
    set_in(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hAA, 1'b1);
    #2;
    n_cmp++;
    if (valA !== 64'h100 || valB !== 64'h100) begin
      n_bad++; $display("FAIL popq_same_cycle: got valA %h valB %h expected 100", valA, valB);
    end
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    n_cmp++;
    if (dbg_data !== 64'hAA) begin
      n_bad++; $display("FAIL popq_r4: got %h expected aa", dbg_data);
    end
  endtask

  task automatic test_stall_invalid;
    dbg_sel = 4'h3;
    @(negedge clk);
    set_in(4'h3, 4'hF, 4'h3, 1'b0, 64'h77, 64'h0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (dbg_data !== 64'h5) begin
      n_bad++; $display("FAIL stall_r3: got %h expected 5", dbg_data);
    end
    set_in(4'hC, 4'h3, 4'h3, 1'b1, 64'h55, 64'h66, 1'b1);
    #2;
    n_cmp++;
    if (decode_err !== 1'b1 || {srcA, srcB, dstE, dstM} !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL invalid_decode: got err %b ids %h expected err 1 ids ffff",
               decode_err, {srcA, srcB, dstE, dstM});
    end
    @(negedge clk);
    wb_en = 1'b0;
    n_cmp++;
    if (dbg_data !== 64'h5) begin
      n_bad++; $display("FAIL invalid_r3: got %h expected 5", dbg_data);
    end
  endtask

  task automatic test_mid_reset;
    dbg_sel = 4'h3;
    @(negedge clk);
    set_in(4'h3, 4'hF, 4'h3, 1'b0, 64'hDEAD, 64'h0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dbg_data !== 64'h0) begin
      n_bad++; $display("FAIL midrst_r3_now: got %h expected 0", dbg_data);
    end
    dbg_sel = 4'h4;
    #1;
    n_cmp++;
    if (dbg_data !== 64'h100) begin
      n_bad++; $display("FAIL midrst_r4_now: got %h expected 100", dbg_data);
    end
    dbg_sel = 4'h3;
    @(negedge clk);
    n_cmp++;
    if (dbg_data !== 64'h0) begin
      n_bad++; $display("FAIL midrst_write_lost: got %h expected 0", dbg_data);
    end
    wb_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dbg_data !== 64'h0) begin
      n_bad++; $display("FAIL postrst_no_write: got %h expected 0", dbg_data);
    end
    wb_en = 1'b1;
    @(negedge clk);
    wb_en = 1'b0;
    n_cmp++;
    if (dbg_data !== 64'hDEAD) begin
      n_bad++; $display("FAIL postrst_write: got %h expected dead", dbg_data);
    end
  endtask

  initial begin
    dbg_sel = 4'h0;
    test_reset;
    test_decode;
    test_opq;
    test_cmov;
    test_popq_rsp;
    test_stall_invalid;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_writeback.md
DECODE_WRITEBACK -- requirements
Module: decode_writeback

Interface
REQ-001 SHALL have parameter RESET_RSP, default 64'h0, which sets the reset value of register 4 (%rsp).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; every write occurs on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports icode and ifun, input, 4 bits each: the instruction fields produced by Fetch.
REQ-005 SHALL have ports rA and rB, input, 4 bits each: the register specifiers from Fetch; 4'hF means no register.
REQ-006 SHALL have port cnd, input, 1 bit: the condition result from execute; it gates the rrmovq/cmovXX write.
REQ-007 SHALL have ports valE and valM, input, 64 bits each: the execute result and the memory read data to write back.
REQ-008 SHALL have port wb_en, input, 1 bit: the write-back enable; 0 means a stall or halt, with no register update.
REQ-009 SHALL have ports srcA, srcB, dstE and dstM, output, 4 bits each: the decoded register IDs.
REQ-010 SHALL have ports valA and valB, output, 64 bits each: the register operands.
REQ-011 SHALL have port decode_err, output, 1 bit: set when icode is greater than 4'hB.
REQ-012 SHALL have port dbg_sel, input, 4 bits, and port dbg_data, output, 64 bits: an asynchronous debug read port.

Function
REQ-013 srcA SHALL be rA for icode 2/4/6/A, 4'h4 for icode 9/B, and 4'hF otherwise.
REQ-014 srcB SHALL be rB for icode 4/5/6, 4'h4 for icode 8/9/A/B, and 4'hF otherwise.
REQ-015 dstE SHALL be (cnd ? rB : 4'hF) for icode 2, rB for icode 3/6, 4'h4 for icode 8/9/A/B, and 4'hF otherwise.
REQ-016 dstM SHALL be rA for icode 5/B and 4'hF otherwise.
REQ-017 For icode greater than 4'hB, all four IDs SHALL be 4'hF and decode_err SHALL be 1; this block is purely combinational and carries no latency.
REQ-018 valA, valB and dbg_data SHALL be combinational reads of the register file, returning 64'h0 for ID 4'hF.
REQ-019 A read in the same cycle as a write to that register SHALL return the old value (no bypass); the new value is visible after the edge.
REQ-020 On a rising clk with wb_en=1, the file SHALL write R[dstE]<=valE when dstE!=F and R[dstM]<=valM when dstM!=F.
REQ-021 When dstE==dstM!=F in the same cycle, the valM write SHALL win (popq %rsp semantics).
REQ-022 Register 4'hF SHALL never be stored; the file SHALL hold exactly 15 registers, each 64 bits wide.
REQ-023 With wb_en=0, all registers SHALL hold their values; the decode outputs still follow the inputs.

Reset
REQ-024 While rst_n=0, registers 0-3 and 5-14 SHALL read 64'h0 and register 4 SHALL read RESET_RSP, immediately and without waiting for clk.
REQ-025 A write pending on the edge at which rst_n is low SHALL be discarded.
REQ-026 Deassertion of rst_n SHALL take effect with no write occurring until the next rising clk with wb_en=1.

Structure
REQ-027 Package y86_pkg SHALL hold the icode constants (IHALT=0 through IPOPQ=B), RNONE=4'hF and RRSP=4'h4.
REQ-028 The register storage SHALL be a sub-module y86_regfile with two read ports, one debug read port and two write ports (E and M), with M priority.
REQ-029 The decode logic SHALL reside in decode_writeback.

Verification
REQ-030 Reset check: assert rst_n=0 with RESET_RSP=64'h100, then sweep dbg_sel 0-14 -> register 4 reads 64'h100, all others read 64'h0, and dbg_sel=F reads 64'h0.
REQ-031 OPq write/read: irmovq (icode 3, rB=3, valE=64'h5, wb_en=1), then OPq (icode 6, rA=0, rB=3) -> valB=64'h5 one cycle later, with srcA=0, srcB=3 and dstE=3.
REQ-032 cmov gating: icode 2, rA=1, rB=2, cnd=0, valE=64'h9 -> dstE=F and R2 unchanged; repeat with cnd=1 -> R2=64'h9.
REQ-033 popq %rsp: icode B, rA=4, valE=64'h108, valM=64'hAA -> R4=64'hAA after the edge; read in the same cycle -> valA=valB=old R4.
REQ-034 Stall and invalid: wb_en=0 with dstE=3 -> R3 holds; icode C -> decode_err=1, all IDs F, and no write.
REQ-035 Mid-cycle reset: pulse rst_n low between edges while a write is pending -> registers cleared at once and the write lost.
